// File: rtl/gpio_debounce.sv
// Per-pin GPIO input conditioning: multi-stage synchronizer, stable-count debounce
// with per-pin bypass, and registered rise/fall edge pulses.
module gpio_debounce #(
    parameter int unsigned WIDTH       = 15,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 io_clock,
    input  logic                 io_reset_n,
    input  logic [WIDTH-1:0]     io_pins_raw,
    input  logic [WIDTH-1:0]     io_pins_writeEnable,
    input  logic [WIDTH-1:0]     io_cfg_debounce_en,
    input  logic [CNT_WIDTH-1:0] io_cfg_threshold,
    output logic [WIDTH-1:0]     io_pins_read,
    output logic [WIDTH-1:0]     io_rise,
    output logic [WIDTH-1:0]     io_fall
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0]                  sample;
    logic [WIDTH-1:0]                  state_q, state_d;
    logic [WIDTH-1:0]                  rise_q, rise_d;
    logic [WIDTH-1:0]                  fall_q, fall_d;
    logic [WIDTH-1:0][CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]                  update;
    logic [CNT_WIDTH-1:0]              thr_m1;

    // Raw pads enter stage 0; the last stage is the synchronized sample.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], io_pins_raw};
        sample = sync_q[SYNC_STAGES-1];
    end

    // A threshold of zero behaves as one, so the compare limit saturates at zero.
    always_comb begin
        thr_m1 = '0;
        if (io_cfg_threshold != '0) begin
            thr_m1 = io_cfg_threshold - CNT_WIDTH'(1);
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        update  = '0;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (!io_cfg_debounce_en[i] || io_pins_writeEnable[i]) begin
                cnt_d[i]  = '0;
                update[i] = (sample[i] != state_q[i]);
            end else if (sample[i] == state_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= thr_m1) begin
                cnt_d[i]  = '0;
                update[i] = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
            end
            if (update[i]) begin
                state_d[i] = sample[i];
            end
            rise_d[i] = update[i] & sample[i];
            fall_d[i] = update[i] & ~sample[i];
        end
    end

    always_ff @(posedge io_clock or negedge io_reset_n) begin
        if (!io_reset_n) begin
            sync_q  <= '0;
            state_q <= '0;
            cnt_q   <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign io_pins_read = state_q;
    assign io_rise      = rise_q;
    assign io_fall      = fall_q;

endmodule

// File: tb/tb_gpio_debounce.sv
// Directed self-checking bench for gpio_debounce (WIDTH=15, CNT_WIDTH=16, SYNC_STAGES=2).
module tb_gpio_debounce;

    localparam int unsigned WIDTH     = 15;
    localparam int unsigned CNT_WIDTH = 16;

    logic                 clk;
    logic                 rst_n;
    logic [WIDTH-1:0]     raw;
    logic [WIDTH-1:0]     we;
    logic [WIDTH-1:0]     den;
    logic [CNT_WIDTH-1:0] thr;
    logic [WIDTH-1:0]     pins_read;
    logic [WIDTH-1:0]     rise;
    logic [WIDTH-1:0]     fall;

    int n_checks;
    int n_fails;

    gpio_debounce dut (
        .io_clock            (clk),
        .io_reset_n          (rst_n),
        .io_pins_raw         (raw),
        .io_pins_writeEnable (we),
        .io_cfg_debounce_en  (den),
        .io_cfg_threshold    (thr),
        .io_pins_read        (pins_read),
        .io_rise             (rise),
        .io_fall             (fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Each call waits n rising edges and returns on the following falling edge.
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic h0, h1, h2, h3;
        int   pulses;
        n_checks = 0;
        n_fails  = 0;
        rst_n = 1'b0;
        raw   = '0;
        we    = '0;
        den   = '1;
        thr   = 16'd4;
        #12;
        check("reset_read", 32'(pins_read), 32'h0);
        check("reset_rise", 32'(rise), 32'h0);
        check("reset_fall", 32'(fall), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(3);
        check("idle_read", 32'(pins_read), 32'h0);

        // Latency N=4: q changes after edge E0+5
        raw[0] = 1'b1;
        cycles(5);
        check("lat_before", 32'(pins_read[0]), 32'h0);
        cycles(1);
        check("lat_read", 32'(pins_read[0]), 32'h1);
        check("lat_rise", 32'(rise), 32'h1);
        cycles(1);
        check("lat_rise_one_cycle", 32'(rise), 32'h0);
        check("lat_hold", 32'(pins_read[0]), 32'h1);
        raw[0] = 1'b0;
        cycles(6);
        check("fall_read", 32'(pins_read[0]), 32'h0);
        check("fall_pulse", 32'(fall), 32'h1);
        cycles(2);

        // Glitch: three synchronized high samples with N=4 are rejected
        pulses = 0;
        raw[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            pulses += int'($countones(rise | fall));
        end
        raw[0] = 1'b0;
        repeat (10) begin
            @(negedge clk);
            pulses += int'($countones(rise | fall));
        end
        check("glitch_read", 32'(pins_read[0]), 32'h0);
        check("glitch_pulses", 32'(pulses), 32'h0);
        raw[0] = 1'b1;
        cycles(5);
        check("glitch_cnt_cleared", 32'(pins_read[0]), 32'h0);
        cycles(1);
        check("glitch_after_read", 32'(pins_read[0]), 32'h1);
        raw[0] = 1'b0;
        cycles(8);

        // Bypass via output-enable on pin 3: read follows raw two edges later
        we[3] = 1'b1;
        thr   = 16'd50;
        h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            h0     = ((k / 2) % 2) == 1;
            raw[3] = h0;
            @(negedge clk);
            check($sformatf("byp_read_%0d", k), 32'(pins_read[3]), 32'(h2));
            check($sformatf("byp_rise_%0d", k), 32'(rise[3]), 32'(h2 & ~h3));
            check($sformatf("byp_fall_%0d", k), 32'(fall[3]), 32'(~h2 & h3));
            h3 = h2; h2 = h1; h1 = h0;
        end
        raw[3] = 1'b0;
        we[3]  = 1'b0;
        cycles(4);

        // N=0 behaves as N=1
        thr    = 16'd0;
        raw[1] = 1'b1;
        cycles(2);
        check("n0_before", 32'(pins_read[1]), 32'h0);
        cycles(1);
        check("n0_read", 32'(pins_read[1]), 32'h1);
        thr    = 16'd1;
        raw[1] = 1'b0;
        cycles(2);
        check("n1_before", 32'(pins_read[1]), 32'h1);
        cycles(1);
        check("n1_read", 32'(pins_read[1]), 32'h0);
        check("n1_fall", 32'(fall), 32'h2);
        cycles(2);

        // Threshold lowered 100 -> 2 with cnt=10 updates on the next edge
        thr    = 16'd100;
        raw[2] = 1'b1;
        cycles(12);
        check("thr_hold", 32'(pins_read[2]), 32'h0);
        thr = 16'd2;
        cycles(1);
        check("thr_read", 32'(pins_read[2]), 32'h1);
        check("thr_rise", 32'(rise), 32'h4);

        // Reset mid-count (pin5 cnt=7) clears everything asynchronously
        thr    = 16'd20;
        raw[5] = 1'b1;
        cycles(9);
        check("pre_reset_read", 32'(pins_read), 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset_read", 32'(pins_read), 32'h0);
        thr = 16'd3;
        @(negedge clk);
        rst_n = 1'b1;
        cycles(4);
        check("rel_before", 32'(pins_read), 32'h0);
        cycles(1);
        check("rel_read", 32'(pins_read), 32'h24);
        check("rel_rise", 32'(rise), 32'h24);
        cycles(1);
        check("rel_rise_one", 32'(rise), 32'h0);

        // Independence: pin0 debounced (N=3), pin14 bypassed, same edge
        den[14] = 1'b0;
        raw[0]  = 1'b1;
        raw[14] = 1'b1;
        cycles(2);
        check("ind_p14_before", 32'(pins_read[14]), 32'h0);
        cycles(1);
        check("ind_p14_read", 32'(pins_read[14]), 32'h1);
        check("ind_p14_rise", 32'(rise), 32'h4000);
        check("ind_p0_wait", 32'(pins_read[0]), 32'h0);
        cycles(2);
        check("ind_p0_read", 32'(pins_read), 32'h4025);
        check("ind_p0_rise", 32'(rise), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
